shift_frame_driver: RTL and testbench
=====================================

Name: shift_frame_driver

Overview:
- Upstream sequencer for the 8-bit serial-in parity shift stage.
- Accepts data words over a valid/ready handshake and drives that stage's start, stop, load, serial_in and parallel_in pins, so each word is shifted in MSB first.
- After each frame it samples the stage's combinational parity output and checks it against locally computed parity.
- Reports done, parity error and a frame count to the control logic.

Parameters:
- DATA_W, 8: word width; must match the downstream shift register width.
- GAP_CYCLES, 1: idle cycles between CHECK and IDLE, range 0..15. A value of 0 goes straight to IDLE.

Ports:
- clock  input  1  rising-edge clock shared with the downstream stage
- resetn  input  1  asynchronous active-low reset shared with the downstream stage
- in_valid  input  1  word offered
- in_data  input  DATA_W  word to send
- in_ready  output  1  driver can accept a word
- sr_start  output  1  to downstream start
- sr_stop  output  1  to downstream stop
- sr_load  output  1  to downstream load
- sr_serial  output  1  to downstream serial_in
- sr_parallel  output  DATA_W  to downstream parallel_in
- sr_parity  input  1  from downstream parity, the XOR of its register
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse per completed frame
- parity_err  output  1  result of the last check, held until the next done
- frame_count  output  8  completed frames, wraps 255 -> 0

Behaviour:
- Reset is asynchronous, active-low, on resetn; clock is clock.
- Reset values: state IDLE; in_ready=1; busy=0; done=0; parity_err=0; frame_count=0; sr_*=0; data latch and bit counter are 0.
- Reset mid-operation aborts the frame immediately. No done pulse and no count change occur. The downstream stage is cleared by the same resetn.
- All sr_* outputs are registered and are decoded from state. sr_parallel is 0 except during LOAD.
- States: IDLE, START, SHIFT, CHECK, GAP (plus LOAD, optional feature only).
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: latch in_data, latch exp_par = XOR of in_data, go to START.
  - in_ready drops in the cycle after acceptance.
- START: one cycle; sr_start=1. The downstream shift_left becomes 1 at the end of this cycle.
- SHIFT: exactly DATA_W cycles.
  - sr_serial = latched bit DATA_W-1-k in shift cycle k (MSB first).
  - sr_stop=1 only in the last shift cycle. The downstream register still shifts on that edge, so exactly DATA_W bits enter.
  - sr_start=0 throughout.
- CHECK: one cycle. Downstream register now equals the latched word.
  - Compare sr_parity with exp_par.
  - At the closing edge: done=1 for one cycle; parity_err = mismatch; frame_count += 1 (mod 256).
- GAP: GAP_CYCLES cycles with all sr_* = 0, then IDLE.
- Latency: from the acceptance edge, done is high in cycle DATA_W+3, which is 11 for default parameters.
- Frame period with in_valid held high: DATA_W+3+GAP_CYCLES cycles. The default is 12.
- in_valid or in_data changes while busy are ignored. No word is lost because in_ready=0 while busy.
- sr_start and sr_stop are never high in the same cycle.
- sr_load=0 whenever the downstream shift_left may be 1.

Optional Feature:
- Macro: SHIFT_FRAME_PARALLEL_EN.
- Defined:
  - in_data bit-width sets nothing new.
  - An extra input `mode_par` (1 bit) is sampled at acceptance.
  - If mode_par=1, the path is IDLE -> LOAD -> CHECK -> GAP. LOAD is one cycle with sr_load=1 and sr_parallel = latched word.
  - Parallel-frame latency to done is 3 cycles.
- Not defined: no mode_par port, no LOAD state; serial path only.

Test Plan:
- Accept 0xA5 with GAP_CYCLES=1:
  - sr_start high in cycle 1.
  - sr_serial sequence 1,0,1,0,0,1,0,1 in cycles 2-9, with sr_stop high in cycle 9.
  - done in cycle 11, parity_err=0, frame_count=1.
- Send 0x01, then 0xFF back-to-back with in_valid held:
  - Accept edges are 12 cycles apart.
  - exp_par is 1 and then 0.
  - No parity_err; frame_count=2.
- Force sr_parity inverted during CHECK for 0x3C:
  - done with parity_err=1.
  - The next clean frame clears parity_err to 0.
- Assert resetn low during shift cycle 4:
  - All outputs return to reset values asynchronously, frame_count=0.
  - After release, a frame with 0x80 completes normally.
- Run 256 frames: frame_count wraps to 0 on the 256th done.
- With SHIFT_FRAME_PARALLEL_EN, mode_par=1, data 0x07:
  - sr_load=1 and sr_parallel=0x07 in cycle 1.
  - done in cycle 3, parity_err=0.

Source files
------------

// File: rtl/shift_frame_driver.sv
// shift_frame_driver: upstream sequencer for the 8-bit serial-in parity shift stage.
// It accepts words over valid/ready and shifts each one MSB first into the stage.
// After each frame it checks the stage's parity output against locally computed parity.
// Optional feature macro: SHIFT_FRAME_PARALLEL_EN adds the mode_par input and the
// LOAD state, which loads a frame in parallel.
module shift_frame_driver #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic              clock,
  input  logic              resetn,
`ifdef SHIFT_FRAME_PARALLEL_EN
  input  logic              mode_par,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sr_start,
  output logic              sr_stop,
  output logic              sr_load,
  output logic              sr_serial,
  output logic [DATA_W-1:0] sr_parallel,
  input  logic              sr_parity,
  output logic              busy,
  output logic              done,
  output logic              parity_err,
  output logic [7:0]        frame_count
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_CHECK,
    S_GAP
`ifdef SHIFT_FRAME_PARALLEL_EN
    , S_LOAD
`endif
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] data;     // latched word, consumed MSB first while shifting
  logic              exp_par;
  logic [CNT_W-1:0]  bit_cnt;
  logic [3:0]        gap_cnt;

  // Frame sequencer. All pin outputs are registered together with the state they belong to.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      data        <= '0;
      exp_par     <= 1'b0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      parity_err  <= 1'b0;
      frame_count <= 8'd0;
      sr_start    <= 1'b0;
      sr_stop     <= 1'b0;
      sr_load     <= 1'b0;
      sr_serial   <= 1'b0;
      sr_parallel <= '0;
    end else begin
      done        <= 1'b0;
      sr_start    <= 1'b0;
      sr_stop     <= 1'b0;
      sr_load     <= 1'b0;
      sr_serial   <= 1'b0;
      sr_parallel <= '0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            data     <= in_data;
            exp_par  <= ^in_data;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef SHIFT_FRAME_PARALLEL_EN
            if (mode_par) begin
              state       <= S_LOAD;
              sr_load     <= 1'b1;
              sr_parallel <= in_data;
            end else
`endif
            begin
              state    <= S_START;
              sr_start <= 1'b1;
            end
          end
        end
        S_START: begin
          // First shift cycle presents the MSB; stop only if the word is one bit wide.
          state     <= S_SHIFT;
          bit_cnt   <= '0;
          sr_serial <= data[DATA_W-1];
          sr_stop   <= (LAST_BIT == '0);
          data      <= data << 1;
        end
        S_SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            state <= S_CHECK;
          end else begin
            bit_cnt   <= bit_cnt + CNT_W'(1);
            sr_serial <= data[DATA_W-1];
            sr_stop   <= ((bit_cnt + CNT_W'(1)) == LAST_BIT);
            data      <= data << 1;
          end
        end
        S_CHECK: begin
          // The downstream register holds the full word here; its parity is compared once.
          done        <= 1'b1;
          parity_err  <= sr_parity ^ exp_par;
          frame_count <= frame_count + 8'd1;
          gap_cnt     <= '0;
          if (GAP_CYCLES == 0) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
`ifdef SHIFT_FRAME_PARALLEL_EN
        S_LOAD: begin
          state <= S_CHECK;
        end
`endif
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_frame_driver.sv
// Testbench for shift_frame_driver with a small behavioural model of the downstream shift stage.
module tb_shift_frame_driver;

  logic       clock;
  logic       resetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       sr_start, sr_stop, sr_load, sr_serial;
  logic [7:0] sr_parallel;
  logic       sr_parity;
  logic       busy, done, parity_err;
  logic [7:0] frame_count;
`ifdef SHIFT_FRAME_PARALLEL_EN
  logic       mode_par;
`endif

  int n_checks;
  int n_fail;
  logic [7:0] exp_count;

  // Downstream stage model
  logic [7:0] ds_reg;
  logic       ds_shift;
  logic       inject;

  shift_frame_driver #(.DATA_W(8), .GAP_CYCLES(1)) dut (
    .clock      (clock),
    .resetn     (resetn),
`ifdef SHIFT_FRAME_PARALLEL_EN
    .mode_par   (mode_par),
`endif
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .sr_start   (sr_start),
    .sr_stop    (sr_stop),
    .sr_load    (sr_load),
    .sr_serial  (sr_serial),
    .sr_parallel(sr_parallel),
    .sr_parity  (sr_parity),
    .busy       (busy),
    .done       (done),
    .parity_err (parity_err),
    .frame_count(frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ds_reg   <= 8'd0;
      ds_shift <= 1'b0;
    end else begin
      if (sr_load) ds_reg <= sr_parallel;
      else if (ds_shift) ds_reg <= {ds_reg[6:0], sr_serial};
      if (sr_start) ds_shift <= 1'b1;
      else if (sr_stop) ds_shift <= 1'b0;
    end
  end

  assign sr_parity = (^ds_reg) ^ inject;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one serial frame and reports what was observed; done_at is -1 on timeout.
  task automatic run_frame(input logic [7:0] d, input logic inj, output logic [7:0] ser,
                           output int done_at, output logic err, output logic [7:0] cnt);
    int w;
    ser = 8'd0; done_at = -1; err = 1'bx; cnt = 8'hxx;
    w = 0;
    while (!in_ready && w < 30) begin step(); w++; end
    if (!in_ready) return;
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc >= 2 && cyc <= 9) ser = {ser[6:0], sr_serial};
      if (cyc == 9) inject = inj;
      if (done) begin
        done_at = cyc; err = parity_err; cnt = frame_count;
        break;
      end
      step();
    end
    inject = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00; inject = 1'b0;
`ifdef SHIFT_FRAME_PARALLEL_EN
    mode_par = 1'b0;
`endif
    #12 resetn = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, busy, done, parity_err, sr_start, sr_stop, sr_load, sr_serial} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 10000000",
               {in_ready, busy, done, parity_err, sr_start, sr_stop, sr_load, sr_serial});
    end
    n_checks++;
    if (frame_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", frame_count); end
    n_checks++;
    if (sr_parallel !== 8'd0) begin n_fail++; $display("FAIL reset_parallel: got %h want 00", sr_parallel); end
    exp_count = 8'd0;
  endtask

  task automatic test_serial_a5();
    logic [7:0] pat;
    pat = 8'hA5;
    step();
    in_valid = 1'b1; in_data = pat;
    step();
    in_valid = 1'b0;
    // cycle 1
    n_checks++;
    if ({sr_start, sr_stop, in_ready, busy} !== 4'b1001) begin
      n_fail++; $display("FAIL a5_start: start/stop/ready/busy got %b want 1001", {sr_start, sr_stop, in_ready, busy});
    end
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if ({sr_serial, sr_stop, sr_start, sr_load} !== {pat[7-k], (k == 7), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL a5_shift%0d: serial/stop/start/load got %b want %b", k,
                 {sr_serial, sr_stop, sr_start, sr_load}, {pat[7-k], (k == 7), 1'b0, 1'b0});
      end
    end
    step(); // cycle 10 CHECK
    n_checks++;
    if ({done, sr_stop, sr_serial} !== 3'b000) begin
      n_fail++; $display("FAIL a5_check: done/stop/serial got %b want 000", {done, sr_stop, sr_serial});
    end
    step(); // cycle 11
    exp_count = exp_count + 8'd1;
    n_checks++;
    if ({done, parity_err, frame_count} !== {1'b1, 1'b0, exp_count}) begin
      n_fail++; $display("FAIL a5_done: done=%b err=%b count=%0d want 1 0 %0d", done, parity_err, frame_count, exp_count);
    end
    step(); // cycle 12
    n_checks++;
    if ({done, in_ready, busy} !== 3'b010) begin
      n_fail++; $display("FAIL a5_idle: done/ready/busy got %b want 010", {done, in_ready, busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ser_a, ser_b;
    logic err_a, err_b, rdy11, rdy12, start_b, rdy_b;
    logic done_a, done_b;
    ser_a = 8'd0; ser_b = 8'd0;
    in_valid = 1'b1; in_data = 8'h01;
    step();
    in_data = 8'hFF;
    done_a = 1'b0; err_a = 1'bx; rdy11 = 1'bx; rdy12 = 1'bx;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc >= 2 && cyc <= 9) ser_a = {ser_a[6:0], sr_serial};
      if (cyc == 11) begin done_a = done; err_a = parity_err; rdy11 = in_ready; end
      if (cyc == 12) rdy12 = in_ready;
      step();
    end
    start_b = sr_start; rdy_b = in_ready;
    in_valid = 1'b0;
    done_b = 1'b0; err_b = 1'bx;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      if (cyc >= 2 && cyc <= 9) ser_b = {ser_b[6:0], sr_serial};
      if (cyc == 11) begin done_b = done; err_b = parity_err; end
      if (cyc < 11) step();
    end
    exp_count = exp_count + 8'd2;
    n_checks++;
    if (ser_a !== 8'h01) begin n_fail++; $display("FAIL b2b_serial_a: got %h want 01", ser_a); end
    n_checks++;
    if ({done_a, err_a} !== 2'b10) begin n_fail++; $display("FAIL b2b_done_a: done/err got %b want 10", {done_a, err_a}); end
    n_checks++;
    if ({rdy11, rdy12, start_b, rdy_b} !== 4'b0110) begin
      n_fail++; $display("FAIL b2b_accept_spacing: ready11/ready12/startB/readyB got %b want 0110", {rdy11, rdy12, start_b, rdy_b});
    end
    n_checks++;
    if (ser_b !== 8'hFF) begin n_fail++; $display("FAIL b2b_serial_b: got %h want ff", ser_b); end
    n_checks++;
    if ({done_b, err_b, frame_count} !== {2'b10, exp_count}) begin
      n_fail++; $display("FAIL b2b_done_b: done=%b err=%b count=%0d want 1 0 %0d", done_b, err_b, frame_count, exp_count);
    end
    step();
  endtask

  task automatic test_parity_error();
    logic [7:0] ser, cnt;
    int done_at;
    logic err;
    run_frame(8'h3C, 1'b1, ser, done_at, err, cnt);
    exp_count = exp_count + 8'd1;
    n_checks++;
    if (done_at !== 11 || err !== 1'b1 || cnt !== exp_count) begin
      n_fail++; $display("FAIL perr_detect: done_at=%0d err=%b count=%0d want 11 1 %0d", done_at, err, cnt, exp_count);
    end
    step();
    n_checks++;
    if ({done, parity_err} !== 2'b01) begin n_fail++; $display("FAIL perr_hold: done/err got %b want 01", {done, parity_err}); end
    run_frame(8'h5A, 1'b0, ser, done_at, err, cnt);
    exp_count = exp_count + 8'd1;
    n_checks++;
    if (done_at !== 11 || err !== 1'b0 || ser !== 8'h5A) begin
      n_fail++; $display("FAIL perr_clear: done_at=%0d err=%b serial=%h want 11 0 5a", done_at, err, ser);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ser, cnt;
    int done_at;
    logic err;
    step();
    in_valid = 1'b1; in_data = 8'hC3;
    step();
    in_valid = 1'b0;
    for (int c = 1; c < 6; c++) step(); // cycle 6 = shift cycle 4
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, busy, done, parity_err, sr_start, sr_stop, sr_load, sr_serial} !== 8'b1000_0000 ||
        frame_count !== 8'd0 || sr_parallel !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_values: flags=%b count=%0d parallel=%h want 10000000 0 00",
               {in_ready, busy, done, parity_err, sr_start, sr_stop, sr_load, sr_serial}, frame_count, sr_parallel);
    end
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    exp_count = 8'd0;
    run_frame(8'h80, 1'b0, ser, done_at, err, cnt);
    exp_count = exp_count + 8'd1;
    n_checks++;
    if (done_at !== 11 || err !== 1'b0 || cnt !== exp_count || ser !== 8'h80) begin
      n_fail++; $display("FAIL midreset_recover: done_at=%0d err=%b count=%0d serial=%h want 11 0 1 80", done_at, err, cnt, ser);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ser, cnt;
    int done_at;
    logic err;
    @(negedge clock) resetn = 1'b0;
    @(negedge clock) resetn = 1'b1;
    exp_count = 8'd0;
    for (int i = 1; i <= 256; i++) begin
      run_frame(8'(i * 7), 1'b0, ser, done_at, err, cnt);
      exp_count = exp_count + 8'd1;
      if (done_at < 0) begin
        n_checks++; n_fail++;
        $display("FAIL wrap_timeout: frame %0d got no done want done", i);
        break;
      end
      if (i == 255) begin
        n_checks++;
        if (cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", cnt); end
      end
      if (i == 256) begin
        n_checks++;
        if (cnt !== exp_count || cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_0: got %0d want 0", cnt); end
      end
    end
  endtask

`ifdef SHIFT_FRAME_PARALLEL_EN
  task automatic test_parallel();
    step(); step();
    mode_par = 1'b1; in_valid = 1'b1; in_data = 8'h07;
    step();
    in_valid = 1'b0; mode_par = 1'b0;
    n_checks++;
    if ({sr_load, sr_start, sr_parallel} !== {2'b10, 8'h07}) begin
      n_fail++; $display("FAIL par_load: load/start got %b parallel %h want 10 07", {sr_load, sr_start}, sr_parallel);
    end
    step();
    n_checks++;
    if ({sr_load, sr_parallel, done} !== {1'b0, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL par_check: load=%b parallel=%h done=%b want 0 00 0", sr_load, sr_parallel, done);
    end
    step();
    exp_count = exp_count + 8'd1;
    n_checks++;
    if ({done, parity_err, frame_count} !== {2'b10, exp_count}) begin
      n_fail++; $display("FAIL par_done: done=%b err=%b count=%0d want 1 0 %0d", done, parity_err, frame_count, exp_count);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_serial_a5();
    test_back_to_back();
    test_parity_error();
    test_reset_mid();
    test_wrap();
`ifdef SHIFT_FRAME_PARALLEL_EN
    test_parallel();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
